// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared occupancy type and default payload constants for pipeline stages.
package pipe_pkg;
    localparam int WORD_W = 32;
    typedef logic [1:0] occ_t;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;
    localparam logic [WORD_W-1:0] NOP_WORD = ZERO_WORD;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake plus controller hold/kill for one stage.
interface pipe_stage_reg_if #(parameter int PAYLOAD_W = 32);
    logic in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [PAYLOAD_W-1:0] in_payload, out_payload;
    pipe_pkg::occ_t occupancy;
    modport master (output in_valid, in_payload, out_ready, stall, flush,
                    input in_ready, out_valid, out_payload, occupancy);
    modport slave (input in_valid, in_payload, out_ready, stall, flush,
                   output in_ready, out_valid, out_payload, occupancy);
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+payload register; clear wins over load.
module pipe_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end
    end
    assign valid_o = valid_q;
    assign q_o     = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall/flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to build the second (skid) slot with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W   = 32,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(NOP_WORD)
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);
    logic                 m_v, m_load, m_clr, acc, iss, rdy_q, rdy_d;
    logic [PAYLOAD_W-1:0] m_q, m_d;
    assign bus.out_valid   = m_v & ~bus.stall;
    assign bus.out_payload = bus.out_valid ? m_q : NOP_PAYLOAD;
    assign iss = bus.out_valid & bus.out_ready;
    assign acc = bus.in_valid & bus.in_ready;
`ifdef PIPE_STAGE_SKID_EN
    logic                 s_v, s_load, s_clr;
    logic [PAYLOAD_W-1:0] s_q;
    // rdy_q mirrors "skid slot empty next cycle", so in_ready never sees out_ready
    assign bus.in_ready  = rdy_q & ~bus.stall;
    assign m_load        = (iss & s_v) | (acc & (~m_v | iss));
    assign m_clr         = bus.flush | (iss & ~s_v & ~acc);
    assign m_d           = (iss & s_v) ? s_q : bus.in_payload;
    assign s_load        = acc & m_v & ~iss;
    assign s_clr         = bus.flush | iss;
    assign rdy_d         = s_clr | ~(s_load | s_v);
    assign bus.occupancy = occ_t'({1'b0, m_v} + {1'b0, s_v});
    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (s_load),
        .clr_i  (s_clr),
        .d_i    (bus.in_payload),
        .valid_o(s_v),
        .q_o    (s_q)
    );
`else
    // rdy_q only keeps in_ready low until the first edge after reset
    assign bus.in_ready  = rdy_q & (~m_v | bus.out_ready) & ~bus.stall;
    assign m_load        = acc;
    assign m_clr         = bus.flush | (iss & ~acc);
    assign m_d           = bus.in_payload;
    assign rdy_d         = 1'b1;
    assign bus.occupancy = occ_t'({1'b0, m_v});
`endif
    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (m_load),
        .clr_i  (m_clr),
        .d_i    (m_d),
        .valid_o(m_v),
        .q_o    (m_q)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= rdy_d;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random and directed stimulus against a queue model of the stage.
module tb_pipe_stage_reg;
    localparam logic [31:0] NOP = 32'h0BAD_F00D;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP  = 2;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = 1;
    localparam bit SKID = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] q[$];
    bit   live = 1'b0;

    pipe_stage_reg_if #(.PAYLOAD_W(32)) bif ();
    pipe_stage_reg #(.PAYLOAD_W(32), .NOP_PAYLOAD(NOP)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_ov();
        return live && q.size() > 0 && !bif.stall;
    endfunction

    function automatic bit exp_ir();
        return live && !bif.stall && (q.size() < CAP || (!SKID && bif.out_ready));
    endfunction

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("out_valid", 32'(bif.out_valid), 32'(exp_ov()));
        chk("in_ready", 32'(bif.in_ready), 32'(exp_ir()));
        chk("out_payload", bif.out_payload, exp_ov() ? q[0] : NOP);
        chk("occupancy", 32'(bif.occupancy), 32'(q.size()));
    end

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            live = 1'b0;
        end else begin
            bit acc, iss;
            acc = bif.in_valid && exp_ir();
            iss = exp_ov() && bif.out_ready;
            if (bif.flush) q.delete();
            else begin
                if (iss) void'(q.pop_front());
                if (acc) q.push_back(bif.in_payload);
            end
            live = 1'b1;
        end
    end

    always @(negedge rst) begin
        q.delete();
        live = 1'b0;
    end

    task automatic set(input bit v, input logic [31:0] p, input bit r, input bit s, input bit f);
        bif.in_valid   = v;
        bif.in_payload = p;
        bif.out_ready  = r;
        bif.stall      = s;
        bif.flush      = f;
    endtask

    task automatic cyc(input bit v, input logic [31:0] p, input bit r, input bit s, input bit f);
        set(v, p, r, s, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        set(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
        chk("rst_payload", bif.out_payload, NOP);
        chk("rst_occ", 32'(bif.occupancy), 32'd0);
        rst = 1'b1;
        cyc(0, 0, 1, 0, 0);
        chk("ready_after_rst", 32'(bif.in_ready), 32'd1);
        cyc(1, 32'h11, 1, 0, 0);
        chk("first_valid", 32'(bif.out_valid), 32'd1);
        chk("first_payload", bif.out_payload, 32'h11);
        chk("first_occ", 32'(bif.occupancy), 32'd1);
        cyc(0, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 32'(i), 1, 0, 0);
            chk("stream_payload", bif.out_payload, 32'(i));
        end
        cyc(0, 0, 1, 0, 0);
        chk("stream_drained", 32'(bif.out_valid), 32'd0);
        cyc(1, 32'hA, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0);
        chk("backpr_occ", 32'(bif.occupancy), 32'(CAP));
        chk("backpr_ready", 32'(bif.in_ready), 32'd0);
        chk("backpr_head", bif.out_payload, 32'hA);
        cyc(1, 32'hB, 1, 0, 0);
        chk("backpr_second", bif.out_payload, 32'hB);
        chk("backpr_ready_back", 32'(bif.in_ready), 32'd1);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 32'hC, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0);
            chk("stall_valid", 32'(bif.out_valid), 32'd0);
            chk("stall_ready", 32'(bif.in_ready), 32'd0);
            chk("stall_payload", bif.out_payload, NOP);
        end
        set(0, 0, 1, 0, 0);
        #1;
        chk("unstall_payload", bif.out_payload, 32'hC);
        @(posedge clk);
        #1;
        cyc(1, 32'h21, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        cyc(1, 32'hD, 0, 0, 1);
        chk("flush_occ", 32'(bif.occupancy), 32'd0);
        chk("flush_valid", 32'(bif.out_valid), 32'd0);
        chk("flush_payload", bif.out_payload, NOP);
        cyc(0, 0, 1, 0, 0);
        chk("flush_no_d", 32'(bif.out_valid), 32'd0);
        repeat (400)
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        cyc(1, 32'h31, 0, 0, 0);
        cyc(1, 32'h32, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bif.out_valid), 32'd0);
        chk("arst_ready", 32'(bif.in_ready), 32'd0);
        chk("arst_payload", bif.out_payload, NOP);
        chk("arst_occ", 32'(bif.occupancy), 32'd0);
        @(posedge clk);
        #1;
        cyc(0, 0, 1, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 1, 0, 0);
        chk("rerelease_ready", 32'(bif.in_ready), 32'd1);
        repeat (200)
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 1) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        cyc(0, 0, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 32; width of the stage payload bus (decoded fields packed by the instantiating stage).
REQ-002 Parameter NOP_PAYLOAD, default all zeros; the bubble value presented whenever no valid beat is held.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  stage can accept a beat.
REQ-007 in_payload  input  PAYLOAD_W  upstream beat data.
REQ-008 out_valid  output  1  downstream beat valid.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_payload  output  PAYLOAD_W  downstream beat data.
REQ-011 stall  input  1  controller hold; freezes the stage.
REQ-012 flush  input  1  controller kill; discards all held beats.
REQ-013 occupancy  output  2  number of beats held (0..2).

Function
REQ-014 Accept transfer SHALL occur when in_valid and in_ready are both high at a clock edge; issue transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 The stage SHALL hold up to two beats (main slot and skid slot); out_payload/out_valid SHALL always come from the main slot.
REQ-016 Latency from accept into an empty stage to out_valid SHALL be exactly 1 cycle.
REQ-017 If out_ready is low while a beat is accepted into an occupied main slot, the beat SHALL go to the skid slot; on the next issue, the skid beat SHALL move to the main slot; beat order SHALL be preserved.
REQ-018 Simultaneous accept and issue with occupancy 1 SHALL keep occupancy 1 and sustain one beat per cycle.
REQ-019 in_ready SHALL be low when occupancy is 2, and SHALL be a registered signal (no combinational path from out_ready).
REQ-020 When stall is high, no accept or issue SHALL occur: in_ready and out_valid SHALL be forced low and all slots SHALL hold.
REQ-021 When flush is high, both slots SHALL be invalidated at that edge, any concurrent accept SHALL be dropped, and flush SHALL take priority over stall.
REQ-022 When out_valid is low, out_payload SHALL equal NOP_PAYLOAD (bubble insertion).
REQ-023 occupancy SHALL count valid slots and never exceed 2.

Reset
REQ-024 While rst is low: out_valid=0, in_ready=0, out_payload=NOP_PAYLOAD, occupancy=0, both slots invalid.
REQ-025 in_ready SHALL rise on the first rising edge of clk after rst deasserts, absent stall.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats immediately without waiting for a clock edge.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN: when defined, the two-slot skid behaviour of REQ-015..REQ-019 SHALL be built.
REQ-028 Without PIPE_STAGE_SKID_EN, only the main slot SHALL exist, in_ready SHALL equal (not out_valid or out_ready) and not stall, occupancy SHALL never exceed 1; all other requirements SHALL hold.

Structure
REQ-029 A shared package pipe_pkg SHALL hold the occupancy typedef, the all-zero word constant and the default NOP payload constant used by all stage instances.
REQ-030 One sub-module pipe_slot (a single valid+payload register with load/clear) SHALL be instantiated for the main and skid slots.

Verification
REQ-031 Reset release, in_valid=1, payload 0x00000011, out_ready=1 -> out_valid=1 with 0x00000011 one cycle later; occupancy=1.
REQ-032 Streaming 0x1,0x2,0x3 back-to-back with out_ready=1 -> outputs 0x1,0x2,0x3 on consecutive cycles, no gaps.
REQ-033 out_ready=0 while sending 0xA,0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB issued in order, in_ready returns to 1.
REQ-034 stall=1 for 3 cycles holding 0xC -> out_valid=0, in_ready=0, out_payload=NOP_PAYLOAD; after stall drops, 0xC issued unchanged.
REQ-035 flush=1 with occupancy 2 and concurrent in_valid beat 0xD -> next cycle occupancy=0, out_valid=0, out_payload=NOP_PAYLOAD, 0xD never issued.
REQ-036 rst low mid-stream with occupancy 2 -> outputs go to reset values without a clock edge; build without PIPE_STAGE_SKID_EN -> occupancy never exceeds 1.
